i2s_transmitter: RTL and testbench
==================================

# i2s_transmitter

Stereo I2S transmitter at the output end of the equalizer datapath. It accepts filtered 24-bit left/right sample pairs through a valid/ready handshake and serializes them to an external DAC as Philips I2S: one-bit delay, MSB first, zero-padded slots. It also generates BCLK and LRCLK and issues a once-per-frame sample strobe that drives the enable input of the upstream filter bank, setting the whole chain's sample rate.

## Interface
- CLK_DIV, 4, i_clk cycles per BCLK half-period (≥2)
- DATA_W, 24, sample width
- SLOT_W, 32, BCLK periods per channel slot; must satisfy SLOT_W > DATA_W (elaboration error otherwise)
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_left  in  DATA_W  signed left sample
- i_right  in  DATA_W  signed right sample
- i_valid  in  1  sample pair valid
- o_ready  out  1  holding register empty, pair accepted when i_valid & o_ready
- o_sample_en  out  1  one-cycle pulse at each frame start (upstream filter enable)
- o_underrun  out  1  one-cycle pulse when a frame starts with no pair held
- o_bclk  out  1  bit clock
- o_lrclk  out  1  word select, 0 = left, 1 = right
- o_sdata  out  1  serial data

## Operation
- Clock is i_clk; reset is i_rst_n, asynchronous, active-low.
- Reset values: o_bclk=0, o_lrclk=0, o_sdata=0, o_ready=1, o_sample_en=0, o_underrun=0. Divider cnt=0. Bit index b=2·SLOT_W−1. Holding register empty. Shift and last-frame registers zero.
- Divider: cnt counts 0..CLK_DIV−1. At cnt=CLK_DIV−1, cnt wraps and o_bclk toggles. A toggle from 1→0 is a falling event.
- On each falling event: b ← (b+1) mod 2·SLOT_W, o_lrclk ← (b_new ≥ SLOT_W), o_sdata ← next bit. All outputs change only on this event.
- Bit mapping within a slot, position k = b mod SLOT_W:
  - k=0 carries padding 0 (one-bit I2S delay).
  - k=1..DATA_W carries the channel sample MSB..LSB.
  - k>DATA_W carries 0.
- Frame start is the falling event with b_new=0:
  - If the holding register is full: move the pair into the shift register, mark holding empty.
  - If it is empty: underrun (see Configuration) and pulse o_underrun.
  - o_sample_en pulses in the same cycle in both cases.
- Handshake: a pair is captured into holding when i_valid & o_ready. o_ready deasserts the following cycle and reasserts the cycle after the frame-start transfer.
- Simultaneous accept and empty-holding frame start in the same cycle: the frame underruns. The accepted pair is stored in holding and sent in the next frame.
- Reset mid-frame: everything returns to reset values immediately. A held pair is discarded.

## Timing
- First BCLK rise comes CLK_DIV cycles after reset release. The first falling event, which is frame 0 start, comes at 2·CLK_DIV.
- Frame length is 2·SLOT_W·2·CLK_DIV i_clk cycles (512 at defaults).
- Latency: a pair accepted before frame start F puts left MSB on o_sdata at the falling event with b=1 of frame F. Right MSB follows at b=SLOT_W+1.
- Throughput: one pair per frame. Upstream sees o_sample_en exactly once per frame.

## Configuration
- I2S_TX_REPEAT_ON_UNDERRUN_EN defined: an underrun frame retransmits the last successfully loaded pair (zero if none since reset).
- Not defined: an underrun frame transmits all-zero slots.
- o_underrun pulses in both builds.

## Structure
- Package i2s_pkg holds DATA_W and SLOT_W defaults, the derived FRAME_BITS = 2·SLOT_W, and the bit-index width localparam.
- Sub-module i2s_clk_gen holds the divider, o_bclk register, bit index b, and the frame-start and falling-event strobes. The top holds the handshake, holding/shift/last registers, and serialization.

## Test plan
- Reset then idle, CLK_DIV=4, SLOT_W=32 → o_bclk period 8 cycles, first fall at cycle 8; o_lrclk toggles every 256 cycles; o_sample_en every 512 cycles; o_underrun pulses each frame; o_sdata stays 0.
- Send L=0x800001, R=0x7FFFFF before frame 1 → frame 1 o_sdata bits k=1..24 are 1000…0001 (left) then 0111…1111 (right); k=0 and k=25..31 are 0; no underrun.
- Hold i_valid high continuously with incrementing pairs → o_ready drops after each accept and reasserts one cycle after each frame start; every pair is transmitted in order, none dropped or duplicated.
- Assert i_valid in the exact frame-start cycle with holding empty → o_underrun pulses; the pair appears in the following frame.
- Send pair 0x123456/0x654321, then starve → with I2S_TX_REPEAT_ON_UNDERRUN_EN the next frame repeats it; without the macro the next frame is all zeros.
- Assert i_rst_n=0 mid right slot with a pair held → outputs return to reset values at once; after release, o_ready=1 and frame 0 underruns.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared defaults and derived sizes for the I2S transmitter slice.
package i2s_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_SLOT_W = 32;
    localparam int FRAME_BITS = 2 * DEF_SLOT_W;

    function automatic int bidx_width(input int slot_w);
        return $clog2(2 * slot_w);
    endfunction

    localparam int BIDX_W = bidx_width(DEF_SLOT_W);

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider and frame bit index; flags the falling BCLK event and the frame start
// one cycle ahead of the registers they update.
module i2s_clk_gen import i2s_pkg::*; #(
    parameter int CLK_DIV = 4,
    parameter int SLOT_W  = DEF_SLOT_W,
    localparam int BW     = bidx_width(SLOT_W)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_bclk,
    output logic          o_fall,
    output logic          o_frame_start,
    output logic [BW-1:0] o_bidx_next
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int FB = 2 * SLOT_W;

    logic [CW-1:0] cnt;
    logic [BW-1:0] bidx;
    logic          wrap;

    assign wrap          = (cnt == CW'(CLK_DIV - 1));
    assign o_fall        = wrap & o_bclk;
    assign o_bidx_next   = (bidx == BW'(FB - 1)) ? '0 : bidx + BW'(1);
    assign o_frame_start = o_fall & (o_bidx_next == '0);

    // Index starts at the last slot bit so the first fall opens frame 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            o_bclk <= 1'b0;
            bidx   <= BW'(FB - 1);
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap) o_bclk <= ~o_bclk;
            if (o_fall) bidx <= o_bidx_next;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S stereo transmitter with a one-pair holding register and frame strobe.
// Define I2S_TX_REPEAT_ON_UNDERRUN_EN to resend the last loaded pair on underrun.
module i2s_transmitter import i2s_pkg::*; #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SLOT_W  = DEF_SLOT_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic signed [DATA_W-1:0] i_left,
    input  logic signed [DATA_W-1:0] i_right,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_sample_en,
    output logic                     o_underrun,
    output logic                     o_bclk,
    output logic                     o_lrclk,
    output logic                     o_sdata
);

    localparam int BW     = bidx_width(SLOT_W);
    localparam int PAIR_W = 2 * DATA_W;

    if (SLOT_W <= DATA_W) begin : g_bad_slot
        $error("SLOT_W must be larger than DATA_W");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be at least 2");
    end

    logic              fall;
    logic              frame_start;
    logic [BW-1:0]     bidx_next;
    logic              full;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [PAIR_W-1:0] shift_q;
    logic [PAIR_W-1:0] underrun_pair;
    logic              right_slot;
    logic [BW-1:0]     slot_pos;
    logic              data_bit;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .SLOT_W  (SLOT_W)
    ) u_clk_gen (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_bclk        (o_bclk),
        .o_fall        (fall),
        .o_frame_start (frame_start),
        .o_bidx_next   (bidx_next)
    );

    assign right_slot = (bidx_next >= BW'(SLOT_W));
    assign slot_pos   = right_slot ? bidx_next - BW'(SLOT_W) : bidx_next;
    assign data_bit   = (slot_pos != '0) && (slot_pos <= BW'(DATA_W));
    assign o_ready    = ~full;

    // Valid/ready: a pair is taken on any cycle with i_valid & o_ready; an accept
    // coinciding with an empty frame start still underruns and waits one frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full   <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else if (i_valid && !full) begin
            full   <= 1'b1;
            hold_l <= i_left;
            hold_r <= i_right;
        end else if (frame_start) begin
            full   <= 1'b0;
        end
    end

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [PAIR_W-1:0] last_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= '0;
        end else if (frame_start && full) begin
            last_q <= {hold_l, hold_r};
        end
    end

    assign underrun_pair = last_q;
`else
    assign underrun_pair = '0;
`endif

    // Left sample sits above right, so one MSB-first shift covers both slots.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q     <= '0;
            o_lrclk     <= 1'b0;
            o_sdata     <= 1'b0;
            o_sample_en <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            o_sample_en <= frame_start;
            o_underrun  <= frame_start & ~full;
            if (fall) begin
                o_lrclk <= right_slot;
                o_sdata <= 1'b0;
                if (frame_start) begin
                    shift_q <= full ? {hold_l, hold_r} : underrun_pair;
                end else if (data_bit) begin
                    o_sdata <= shift_q[PAIR_W-1];
                    shift_q <= {shift_q[PAIR_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: time-based frame model, per-cycle compare, literal pins.
module tb_i2s_transmitter;

    localparam int CD = 4;
    localparam int DW = 24;
    localparam int SW = 32;
    localparam int FB = 2 * SW;
    localparam int FL = FB * 2 * CD;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [DW-1:0] i_left = '0;
    logic [DW-1:0] i_right = '0;
    logic          i_valid = 1'b0;
    logic          o_ready, o_sample_en, o_underrun, o_bclk, o_lrclk, o_sdata;

    int n_checks = 0;
    int n_fail   = 0;

    i2s_transmitter #(.CLK_DIV(CD), .DATA_W(DW), .SLOT_W(SW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_left      (i_left),
        .i_right     (i_right),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_sample_en (o_sample_en),
        .o_underrun  (o_underrun),
        .o_bclk      (o_bclk),
        .o_lrclk     (o_lrclk),
        .o_sdata     (o_sdata)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- model ----------------
    int              t = 0;
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] cur_pair = '0;
    logic [2*DW-1:0] last_pair = '0;
    bit              fs_now = 1'b0;
    bit              under_now = 1'b0;

    initial begin
        forever begin
            @(posedge i_clk or negedge i_rst_n);
            if (!i_rst_n) begin
                t = 0;
                exp_q.delete();
                cur_pair  = '0;
                last_pair = '0;
                fs_now    = 1'b0;
                under_now = 1'b0;
            end else begin
                bit acc;
                acc = i_valid && (exp_q.size() == 0);
                t++;
                fs_now    = (t >= 2 * CD) && (((t - 2 * CD) % FL) == 0);
                under_now = 1'b0;
                if (fs_now) begin
                    if (exp_q.size() > 0) begin
                        cur_pair  = exp_q.pop_front();
                        last_pair = cur_pair;
                    end else begin
                        under_now = 1'b1;
                        cur_pair  = REPEAT ? last_pair : '0;
                    end
                end
                if (acc) exp_q.push_back({i_left, i_right});
            end
        end
    end

    task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    // ---------------- per-cycle scoreboard compare ----------------
    initial begin
        forever begin
            int f, b, k;
            logic [DW-1:0] s;
            logic e_bclk, e_lr, e_sd;
            @(negedge i_clk);
            e_bclk = ((t / CD) % 2) == 1;
            f = t / (2 * CD);
            e_lr = 1'b0;
            e_sd = 1'b0;
            if (f > 0) begin
                b = (f - 1) % FB;
                e_lr = (b >= SW);
                k = b % SW;
                s = e_lr ? cur_pair[DW-1:0] : cur_pair[2*DW-1:DW];
                if (k >= 1 && k <= DW) e_sd = s[DW-k];
            end
            check("bclk", o_bclk, e_bclk);
            check("lrclk", o_lrclk, e_lr);
            check("sdata", o_sdata, e_sd);
            check("ready", o_ready, exp_q.size() == 0);
            check("sample_en", o_sample_en, fs_now);
            check("underrun", o_underrun, fs_now && under_now);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic at_t(input int target);
        int g = 0;
        while (t < target && g < 4 * FL) begin
            @(negedge i_clk);
            g++;
        end
        check("at_time", t, target);
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit keep);
        int g = 0;
        i_valid = 1'b1;
        i_left  = l;
        i_right = r;
        while (!o_ready && g < 3 * FL) begin
            @(negedge i_clk);
            g++;
        end
        check("send_ready", o_ready, 1'b1);
        @(negedge i_clk);
        if (!keep) i_valid = 1'b0;
    endtask

    function automatic int next_fs(input int now);
        if (now < 2 * CD) return 2 * CD;
        return 2 * CD + ((now - 2 * CD) / FL + 1) * FL;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_bclk"}, o_bclk, 1'b0);
        check({tag, "_lrclk"}, o_lrclk, 1'b0);
        check({tag, "_sdata"}, o_sdata, 1'b0);
        check({tag, "_ready"}, o_ready, 1'b1);
        check({tag, "_sample_en"}, o_sample_en, 1'b0);
        check({tag, "_underrun"}, o_underrun, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fs4, fs_a, fs_b;
        repeat (3) @(negedge i_clk);
        check_reset_values("rst0");
        #2 i_rst_n = 1'b1;

        // Idle frame 0: timing of BCLK, LRCLK and the frame strobe.
        at_t(3);   check("bclk_pre_rise", o_bclk, 1'b0);
        at_t(4);   check("bclk_first_rise", o_bclk, 1'b1);
        at_t(7);   check("sen_pre", o_sample_en, 1'b0);
        at_t(8);   check("sen_f0", o_sample_en, 1'b1);
                   check("urun_f0", o_underrun, 1'b1);
                   check("sdata_f0", o_sdata, 1'b0);
        at_t(263); check("lr_pre", o_lrclk, 1'b0);
        at_t(264); check("lr_right", o_lrclk, 1'b1);

        // Boundary pair for frame 1.
        at_t(300);
        send_pair(24'h800001, 24'h7FFFFF, 1'b0);
        at_t(520); check("sen_f1", o_sample_en, 1'b1);
                   check("urun_f1", o_underrun, 1'b0);
        at_t(528); check("l_msb", o_sdata, 1'b1);
        at_t(536); check("l_b22", o_sdata, 1'b0);
        at_t(712); check("l_lsb", o_sdata, 1'b1);
        at_t(720); check("l_pad", o_sdata, 1'b0);
        at_t(776); check("r_delay", o_sdata, 1'b0);
                   check("r_lr", o_lrclk, 1'b1);
        at_t(784); check("r_msb", o_sdata, 1'b0);
        at_t(792); check("r_b22", o_sdata, 1'b1);
        at_t(968); check("r_lsb", o_sdata, 1'b1);
        at_t(976); check("r_pad", o_sdata, 1'b0);

        // Continuous valid with incrementing pairs.
        begin
            logic [DW-1:0] base;
            base = DW'($urandom);
            for (int i = 0; i < 6; i++) send_pair(base + DW'(i), ~(base + DW'(i)), 1'b1);
            i_valid = 1'b0;
        end

        // Randomized pairs with random gaps.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 600)) @(negedge i_clk);
            send_pair(DW'($urandom), DW'($urandom), 1'b0);
        end

        // Accept exactly in an empty frame-start cycle.
        fs4 = next_fs(t) + FL;
        at_t(fs4 - 1);
        i_valid = 1'b1;
        i_left  = 24'hA5A5A5;
        i_right = 24'h5A5A5A;
        @(negedge i_clk);
        i_valid = 1'b0;
        check("sim_urun", o_underrun, 1'b1);
        check("sim_sen", o_sample_en, 1'b1);
        check("sim_ready", o_ready, 1'b0);
        at_t(fs4 + FL + 2 * CD); check("sim_next_msb", o_sdata, 1'b1);

        // Send one pair then starve.
        fs_a = fs4 + FL;
        send_pair(24'h123456, 24'h654321, 1'b0);
        fs_b = fs_a + 2 * FL;
        at_t(fs_b);                 check("starve_urun", o_underrun, 1'b1);
        at_t(fs_b + 4 * 2 * CD);    check("starve_l_b20", o_sdata, REPEAT);
        at_t(fs_b + 34 * 2 * CD);   check("starve_r_b22", o_sdata, REPEAT);

        // Reset mid right slot with a pair held.
        send_pair(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        at_t(fs_b + 40 * 2 * CD);
        #2 i_rst_n = 1'b0;
        #1 check_reset_values("rst_mid");
        repeat (3) @(negedge i_clk);
        check_reset_values("rst_hold");
        #2 i_rst_n = 1'b1;
        check("post_rst_ready", o_ready, 1'b1);
        at_t(8); check("post_rst_urun", o_underrun, 1'b1);
                 check("post_rst_sen", o_sample_en, 1'b1);
        at_t(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog t=%0d actual=timeout expected=finish", t);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
